// File: rtl/fwd_unit_pkg.sv
// Shared types and constants for the operand-forwarding / load-use interlock controller.
package fwd_unit_pkg;

    localparam int REG_AW = 4;

    localparam logic [1:0] SEL_BUFF2 = 2'b00;
    localparam logic [1:0] SEL_ALU   = 2'b01;
    localparam logic [1:0] SEL_WB    = 2'b11;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic              ld;
        logic [REG_AW-1:0] dst;
    } stage_tag_t;

    // buffer2 also carries the consumer side of the instruction
    typedef struct packed {
        stage_tag_t        tag;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic              use1;
        logic              use2;
    } s2_tag_t;

    typedef enum logic {
        RUN     = 1'b0,
        LDSTALL = 1'b1
    } ilock_state_t;

endpackage

// File: rtl/fwd_unit_sel.sv
// Per-operand forwarding priority compare; one instance per operand mux (m2, m3).
module fwd_sel
    import fwd_unit_pkg::*;
#(
    parameter logic [REG_AW-1:0] ZERO_REG = '0
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              use_i,
    input  logic              s2_valid_i,
    input  stage_tag_t        s3_i,
    input  logic              s4_valid_i,
    input  logic              s4_wr_i,
    input  logic [REG_AW-1:0] s4_dst_i,
    output logic [1:0]        sel_o,
    output logic              ld_hit_o
);

    logic live;
    logic s3Hit;
    logic s4Hit;

    // A load sitting in S3 cannot supply its data yet, so it masks any older S4 match
    always_comb begin
        live     = s2_valid_i && use_i && (src_i != ZERO_REG);
        s3Hit    = live && s3_i.valid && s3_i.wr && (s3_i.dst == src_i);
        s4Hit    = live && s4_valid_i && s4_wr_i && (s4_dst_i == src_i);
        ld_hit_o = s3Hit && s3_i.ld;
        sel_o    = SEL_BUFF2;
        if (s3Hit) begin
            sel_o = s3_i.ld ? SEL_BUFF2 : SEL_ALU;
        end else if (s4Hit) begin
            sel_o = SEL_WB;
        end
    end

endmodule

// File: rtl/fwd_unit.sv
// Operand-forwarding and load-use interlock controller with a shadow tag pipeline.
// Optional FWD_PERF_EN adds saturating forward/stall cycle counters.
module fwd_unit
    import fwd_unit_pkg::*;
#(
    parameter int                REG_AW   = fwd_unit_pkg::REG_AW,
    parameter logic [REG_AW-1:0] ZERO_REG = '0
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [REG_AW-1:0] in_dst_id,
    input  logic              in_wr_id,
    input  logic              in_ld_id,
    input  logic [REG_AW-1:0] in_src1_id,
    input  logic [REG_AW-1:0] in_src2_id,
    input  logic              in_use1_id,
    input  logic              in_use2_id,
    input  logic              in_flush,
    output logic [1:0]        out_cntrl_m2,
    output logic [1:0]        out_cntrl_m3,
    output logic              out_stall
`ifdef FWD_PERF_EN
    ,
    output logic [15:0]       out_fwd_cnt,
    output logic [15:0]       out_stall_cnt
`endif
);

    s2_tag_t      s2_q, s2_d;
    stage_tag_t   s3_q, s3_d;
    stage_tag_t   s4_q, s4_d;
    ilock_state_t state_q, state_d;

    logic ldHit1;
    logic ldHit2;

    fwd_sel #(.ZERO_REG(ZERO_REG)) u_sel_m2 (
        .src_i      (s2_q.src1),
        .use_i      (s2_q.use1),
        .s2_valid_i (s2_q.tag.valid),
        .s3_i       (s3_q),
        .s4_valid_i (s4_q.valid),
        .s4_wr_i    (s4_q.wr),
        .s4_dst_i   (s4_q.dst),
        .sel_o      (out_cntrl_m2),
        .ld_hit_o   (ldHit1)
    );

    fwd_sel #(.ZERO_REG(ZERO_REG)) u_sel_m3 (
        .src_i      (s2_q.src2),
        .use_i      (s2_q.use2),
        .s2_valid_i (s2_q.tag.valid),
        .s3_i       (s3_q),
        .s4_valid_i (s4_q.valid),
        .s4_wr_i    (s4_q.wr),
        .s4_dst_i   (s4_q.dst),
        .sel_o      (out_cntrl_m3),
        .ld_hit_o   (ldHit2)
    );

    // A flush kills the consumer, so the pending stall request is dropped
    assign out_stall = (ldHit1 || ldHit2) && !in_flush && (state_q == RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (out_stall) state_d = LDSTALL;
            LDSTALL: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        s4_d            = s3_q;
        s3_d            = s2_q.tag;
        s2_d.tag.valid  = 1'b1;
        s2_d.tag.wr     = in_wr_id;
        s2_d.tag.ld     = in_ld_id;
        s2_d.tag.dst    = in_dst_id;
        s2_d.src1       = in_src1_id;
        s2_d.src2       = in_src2_id;
        s2_d.use1       = in_use1_id;
        s2_d.use2       = in_use2_id;
        if (in_flush) begin
            s3_d = '0;
            s2_d = '0;
        end else if (out_stall) begin
            s3_d = '0;
            s2_d = s2_q;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            s2_q    <= '0;
            s3_q    <= '0;
            s4_q    <= '0;
            state_q <= RUN;
        end else begin
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            s4_q    <= s4_d;
            state_q <= state_d;
        end
    end

`ifdef FWD_PERF_EN
    logic [15:0] fwd_cnt_q;
    logic [15:0] stall_cnt_q;
    logic        anyFwd;

    assign anyFwd = (out_cntrl_m2 != SEL_BUFF2) || (out_cntrl_m3 != SEL_BUFF2);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (anyFwd && (fwd_cnt_q != CNT_MAX)) begin
                fwd_cnt_q <= fwd_cnt_q + 16'd1;
            end
            if (out_stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign out_fwd_cnt   = fwd_cnt_q;
    assign out_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_unit.sv
// Self-checking bench for fwd_unit: directed hazard scenarios plus randomized traffic against a tag-history model.
module tb_fwd_unit;

    logic       in_clk = 1'b0;
    logic       in_rst = 1'b1;
    logic [3:0] in_dst_id = '0;
    logic       in_wr_id = 1'b0;
    logic       in_ld_id = 1'b0;
    logic [3:0] in_src1_id = '0;
    logic [3:0] in_src2_id = '0;
    logic       in_use1_id = 1'b0;
    logic       in_use2_id = 1'b0;
    logic       in_flush = 1'b0;
    logic [1:0] out_cntrl_m2;
    logic [1:0] out_cntrl_m3;
    logic       out_stall;
`ifdef FWD_PERF_EN
    logic [15:0] out_fwd_cnt;
    logic [15:0] out_stall_cnt;
`endif

    int  compared   = 0;
    int  mismatched = 0;
    bit  checkEn    = 1'b0;

    always #5 in_clk = ~in_clk;

    fwd_unit dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_dst_id    (in_dst_id),
        .in_wr_id     (in_wr_id),
        .in_ld_id     (in_ld_id),
        .in_src1_id   (in_src1_id),
        .in_src2_id   (in_src2_id),
        .in_use1_id   (in_use1_id),
        .in_use2_id   (in_use2_id),
        .in_flush     (in_flush),
        .out_cntrl_m2 (out_cntrl_m2),
        .out_cntrl_m3 (out_cntrl_m3),
        .out_stall    (out_stall)
`ifdef FWD_PERF_EN
        ,
        .out_fwd_cnt  (out_fwd_cnt),
        .out_stall_cnt(out_stall_cnt)
`endif
    );

    // Model: one record per instruction occupying buffer2/3/4
    typedef struct {
        bit v;
        bit wr;
        bit ld;
        int dst;
        int s1;
        int s2;
        bit u1;
        bit u2;
    } minst_t;

    minst_t mS2, mS3, mS4;
    int     mFwd   = 0;
    int     mStall = 0;
    bit     mSt;

    function automatic int expSel(input int src, input bit used);
        if (!mS2.v || !used || src == 0) return 0;
        if (mS3.v && mS3.wr && mS3.dst == src) return mS3.ld ? 0 : 1;
        if (mS4.v && mS4.wr && mS4.dst == src) return 3;
        return 0;
    endfunction

    function automatic bit loadMatch(input int src, input bit used);
        return mS2.v && used && src != 0 && mS3.v && mS3.wr && mS3.ld && mS3.dst == src;
    endfunction

    function automatic bit expStall();
        return (loadMatch(mS2.s1, mS2.u1) || loadMatch(mS2.s2, mS2.u2)) && !in_flush;
    endfunction

    initial begin
        mS2 = '{default: 0};
        mS3 = '{default: 0};
        mS4 = '{default: 0};
    end

    always @(posedge in_clk) begin
        if (in_rst) begin
            mS2.v = 0; mS3.v = 0; mS4.v = 0;
            mFwd = 0; mStall = 0;
        end else begin
            mSt = expStall();
            if ((expSel(mS2.s1, mS2.u1) != 0 || expSel(mS2.s2, mS2.u2) != 0) && mFwd < 65535)
                mFwd = mFwd + 1;
            if (mSt && mStall < 65535) mStall = mStall + 1;
            mS4 = mS3;
            if (in_flush) begin
                mS3.v = 0;
                mS2.v = 0;
            end else if (mSt) begin
                mS3.v = 0;
            end else begin
                mS3 = mS2;
                mS2 = '{1, in_wr_id, in_ld_id, int'(in_dst_id), int'(in_src1_id),
                        int'(in_src2_id), in_use1_id, in_use2_id};
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge in_clk) begin
        if (checkEn) begin
            checkOutput("model_m2", 32'(out_cntrl_m2), 32'(expSel(mS2.s1, mS2.u1)));
            checkOutput("model_m3", 32'(out_cntrl_m3), 32'(expSel(mS2.s2, mS2.u2)));
            checkOutput("model_stall", 32'(out_stall), 32'(expStall()));
`ifdef FWD_PERF_EN
            checkOutput("model_fwd_cnt", 32'(out_fwd_cnt), 32'(mFwd));
            checkOutput("model_stall_cnt", 32'(out_stall_cnt), 32'(mStall));
`endif
        end
    end

    task automatic applyStimulus(input int dst, input bit wr, input bit ld, input int s1,
                                 input int s2, input bit u1, input bit u2, input bit fl);
        in_dst_id  = 4'(dst);
        in_wr_id   = wr;
        in_ld_id   = ld;
        in_src1_id = 4'(s1);
        in_src2_id = 4'(s2);
        in_use1_id = u1;
        in_use2_id = u2;
        in_flush   = fl;
        @(posedge in_clk);
        #1;
    endtask

    task automatic nop2();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkNow(input string name, input int m2, input int m3, input int st);
        checkOutput({name, "_m2"}, 32'(out_cntrl_m2), 32'(m2));
        checkOutput({name, "_m3"}, 32'(out_cntrl_m3), 32'(m3));
        checkOutput({name, "_stall"}, 32'(out_stall), 32'(st));
    endtask

    initial begin
        // reset with arbitrary decode inputs
        in_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_dst_id  = 4'($urandom_range(0, 15));
            in_src1_id = 4'($urandom_range(0, 15));
            in_src2_id = 4'($urandom_range(0, 15));
            in_wr_id   = 1'($urandom);
            in_ld_id   = 1'($urandom);
            in_use1_id = 1'b1;
            in_use2_id = 1'b1;
            @(posedge in_clk);
            #1;
            checkEn = 1'b1;
        end
        checkNow("reset", 0, 0, 0);
        in_rst = 1'b0;

        applyStimulus(1, 1, 0, 3, 4, 1, 1, 0);
        checkNow("first", 0, 0, 0);
        nop2();

        applyStimulus(3, 1, 0, 1, 2, 1, 1, 0);
        applyStimulus(8, 1, 0, 3, 7, 1, 1, 0);
        checkNow("alu_fwd", 1, 0, 0);
        nop2();

        applyStimulus(5, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(9, 1, 0, 1, 1, 0, 0, 0);
        applyStimulus(10, 1, 0, 0, 5, 1, 1, 0);
        checkNow("wb_fwd", 0, 3, 0);
        nop2();

        applyStimulus(2, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(2, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(11, 1, 0, 2, 6, 1, 1, 0);
        checkNow("youngest", 1, 0, 0);
        nop2();

        applyStimulus(4, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(12, 1, 0, 4, 4, 1, 1, 0);
        checkNow("ld_stall", 0, 0, 1);
        applyStimulus(13, 1, 0, 1, 1, 0, 0, 0);
        checkNow("ld_after", 3, 3, 0);
        applyStimulus(13, 1, 0, 1, 1, 0, 0, 0);
        checkNow("ld_resume", 0, 0, 0);
        applyStimulus(14, 1, 0, 12, 0, 1, 0, 0);
        checkNow("hold_chain", 3, 0, 0);
        nop2();

        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(2, 1, 1, 1, 0, 1, 0, 0);
        checkNow("b2b_1", 0, 0, 1);
        applyStimulus(3, 1, 0, 2, 0, 1, 0, 0);
        checkNow("b2b_1a", 3, 0, 0);
        applyStimulus(3, 1, 0, 2, 0, 1, 0, 0);
        checkNow("b2b_2", 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkNow("b2b_2a", 3, 0, 0);
        nop2();

        applyStimulus(6, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(7, 1, 0, 6, 6, 1, 1, 0);
        checkNow("pre_flush", 0, 0, 1);
        in_flush = 1'b1;
        #1;
        checkNow("flush_drop", 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkNow("flush_bub", 0, 0, 0);
        applyStimulus(8, 1, 0, 6, 6, 1, 1, 0);
        checkNow("flush_after", 0, 0, 0);
        nop2();

        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(5, 1, 0, 0, 0, 1, 1, 0);
        checkNow("r0", 0, 0, 0);
        nop2();

        applyStimulus(3, 1, 0, 0, 0, 0, 0, 0);
        in_rst = 1'b1;
        applyStimulus(9, 1, 0, 3, 3, 1, 1, 0);
        checkNow("rst_mid", 0, 0, 0);
        in_rst = 1'b0;
        applyStimulus(9, 1, 0, 3, 3, 1, 1, 0);
        checkNow("rst_clean", 0, 0, 0);

        // randomized traffic over a small register window to provoke frequent hazards
        for (int i = 0; i < 600; i++) begin
            in_rst = ($urandom_range(0, 79) == 0);
            applyStimulus($urandom_range(0, 7), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                          $urandom_range(0, 7), $urandom_range(0, 7),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                          $urandom_range(0, 11) == 0);
        end
        in_rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge in_clk);
        #1;
        checkEn = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fwd_unit.md
# fwd_unit

Operand-forwarding and load-use interlock controller for the 16-bit pipelined datapath. Keeps a shadow pipeline of destination-register tags for the buffer2 (execute), buffer3 (memory) and buffer4 (writeback) stages. From it, generates the select codes for operand muxes m2 (operand 1) and m3 (operand 2). Raises a one-cycle stall on load-use hazards so the m2/m3 muxes never pass a stale register value to the ALU.

## Interface
Parameters:
- REG_AW, 4, register-address width (16 registers)
- ZERO_REG, 0, register address never forwarded and never stalled on

Ports:
- in_clk  input  1  pipeline clock, rising edge
- in_rst  input  1  synchronous, active-high reset
- in_dst_id  input  REG_AW  destination register of the instruction leaving decode
- in_wr_id  input  1  instruction leaving decode writes a register
- in_ld_id  input  1  instruction leaving decode is a load
- in_src1_id, in_src2_id  input  REG_AW  source registers of the instruction leaving decode
- in_use1_id, in_use2_id  input  1  the corresponding source is actually read
- in_flush  input  1  branch flush: kill the decode-side and buffer2 instructions
- out_cntrl_m2  output  2  operand-1 select: 00 buffer2, 01 ALU result in buffer3, 11 m5 writeback value
- out_cntrl_m3  output  2  operand-2 select, same encoding
- out_stall  output  1  hold PC, buffer1 and buffer2; inject bubble into buffer3

## Operation
- Shadow stages S2, S3 and S4 each hold {valid, wr, ld, dst}. S2 also holds {src1, src2, use1, use2}.
- Reset:
  - all valid bits are 0
  - out_cntrl_m2 = out_cntrl_m3 = 00
  - out_stall = 0
- Normal advance (no stall, no flush): S4 <= S3, S3 <= S2, S2 <= decode inputs (valid = 1).
- Stall: S4 <= S3, S3 <= bubble (valid = 0), S2 holds.
- Flush: S2 <= bubble and S3 <= S2 is replaced by a bubble. Flush overrides stall; the stall request is dropped.
- Per-operand select, evaluated independently for src1 → m2 and src2 → m3. Let srcN be the S2 source and useN its use flag:
  - If useN = 0, or srcN = ZERO_REG, or S2 is invalid: select 00.
  - Else if S3 is valid, S3.wr = 1, S3.ld = 0 and S3.dst = srcN: select 01. The youngest producer wins.
  - Else if S4 is valid, S4.wr = 1 and S4.dst = srcN: select 11.
  - Else select 00.
  - Code 10 is never driven. Downstream treats 10 as 00.
- Load-use: out_stall = 1 when S2 is valid, S3 is valid with S3.ld = 1 and S3.wr = 1, and S3.dst matches a used, non-ZERO_REG source of S2.
  - While stalled, the select for the matching operand is 00. The value is don't-care because the bubble discards the result.
- Interlock state machine:
  - States: RUN, LDSTALL.
  - RUN → LDSTALL on a load-use hazard (out_stall = 1).
  - LDSTALL → RUN unconditionally on the next edge. The load is now in S4 and the consumer selects 11.
  - A stall never lasts more than one cycle per load.
  - Back-to-back dependent loads each stall once.

## Timing
- out_cntrl_m2, out_cntrl_m3 and out_stall are combinational from the registered shadow state. They are valid in the same cycle the operands sit in buffer2.
- One edge of latency from decode inputs to the shadow S2.
- Load-use penalty: exactly 1 cycle.
- Reset mid-operation clears all stages at the next edge; no stale forward is produced afterwards.

## Configuration
- FWD_PERF_EN defined: adds two 16-bit outputs.
  - out_fwd_cnt counts cycles in which any select is non-00.
  - out_stall_cnt counts stall cycles.
  - Both are synchronous-reset to 0 and saturate at 16'hFFFF.
- FWD_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - select-code constants SEL_BUFF2 = 2'b00, SEL_ALU = 2'b01, SEL_WB = 2'b11
  - the stage-tag struct typedef
  - REG_AW
- One sub-module, fwd_sel: the combinational per-operand priority compare. It is instantiated twice, once for m2 and once for m3.

## Test plan
- Reset asserted with arbitrary inputs → selects 00 and stall 0. The first instruction after reset gets select 00.
- ADD R3 followed immediately by an instruction using src1 = R3 → out_cntrl_m2 = 01 and out_cntrl_m3 = 00 in the consumer's buffer2 cycle.
- Producer R5, an independent instruction, then a consumer with src2 = R5 → out_cntrl_m3 = 11.
- Same destination R2 in S3 and S4, consumer reads R2 → select 01 (youngest wins).
- LOAD R4 followed by a consumer of R4 on both operands:
  - out_stall = 1 for exactly one cycle
  - next cycle both selects = 11
  - PC hold observed for one cycle
- Flush and load-use stall asserted in the same cycle → out_stall is dropped and S2/S3 become bubbles. A source of R0 never forwards or stalls. Under FWD_PERF_EN, the counters match the scenario totals.
